// File: rtl/motor_encoder_emu.sv
// Motor + encoder emulator: measures driver PWM duty per frame, lags it into a speed,
// and turns that speed into an encoder square wave through a phase accumulator.
module motor_encoder_emu #(
  parameter int PWM_PERIOD  = 16384,
  parameter int DW          = 15,
  parameter int PHASE_MAX   = 16777216,
  parameter int LAG_SHIFT   = 2,
  parameter int BRAKE_SHIFT = 0
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          pwm,
  input  logic          in1,
  input  logic          in2,
  input  logic          stnby,
  output logic          fb,
  output logic          dir,
  output logic [DW-1:0] speed,
  output logic [DW-1:0] duty_meas,
  output logic          frame_tick
);

  localparam int              CW   = $clog2(PWM_PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(PWM_PERIOD - 1);
  localparam logic [31:0]     PMAX = 32'(PHASE_MAX);

  typedef enum logic [1:0] {CMD_COAST, CMD_FWD, CMD_REV, CMD_BRAKE} cmd_t;

  logic [CW-1:0]      frame_cnt;
  logic [DW-1:0]      high_cnt;
  logic [31:0]        phase;
  logic [31:0]        phase_sum;
  cmd_t               cmd;
  cmd_t               cmd_dec;
  logic               drive;
  logic               req_dir;
  logic [DW-1:0]      target;
  logic signed [DW:0] delta;
  logic signed [DW:0] step;
  logic [DW-1:0]      next_speed;

  always_comb begin
    cmd_dec = CMD_COAST;
    if (stnby) begin
      case ({in1, in2})
        2'b10:   cmd_dec = CMD_FWD;
        2'b01:   cmd_dec = CMD_REV;
        2'b11:   cmd_dec = CMD_BRAKE;
        default: cmd_dec = CMD_COAST;
      endcase
    end
  end

  // A direction request against the current rotation first spins the motor down to zero.
  always_comb begin
    drive   = (cmd == CMD_FWD) || (cmd == CMD_REV);
    req_dir = (cmd == CMD_FWD);
    target  = '0;
    if (drive && (req_dir == dir))
      target = duty_meas;
    delta = $signed({1'b0, target}) - $signed({1'b0, speed});
    step  = (cmd == CMD_BRAKE) ? (delta >>> BRAKE_SHIFT) : (delta >>> LAG_SHIFT);
    // Floor shifting can stall short of target; a unit step guarantees exact convergence.
    if ((step == '0) && (delta != '0))
      step = delta[DW] ? '1 : (DW+1)'(1);
    next_speed = speed + step[DW-1:0];
    phase_sum  = phase + 32'(speed);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      frame_cnt  <= '0;
      high_cnt   <= '0;
      duty_meas  <= '0;
      frame_tick <= 1'b0;
      cmd        <= CMD_COAST;
      speed      <= '0;
      dir        <= 1'b1;
      phase      <= '0;
      fb         <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (frame_cnt == LAST) begin
        frame_cnt  <= '0;
        duty_meas  <= high_cnt + DW'(pwm);
        high_cnt   <= '0;
        frame_tick <= 1'b1;
        cmd        <= cmd_dec;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
        high_cnt  <= high_cnt + DW'(pwm);
      end

      if (frame_tick) begin
        speed <= next_speed;
        if (drive && (req_dir != dir) && (speed == '0))
          dir <= req_dir;
      end

      if (phase_sum >= PMAX) begin
        phase <= phase_sum - PMAX;
        fb    <= ~fb;
      end else begin
        phase <= phase_sum;
      end
    end
  end

endmodule

// File: tb/tb_motor_encoder_emu.sv
// Directed bench for motor_encoder_emu, scaled to a 256-cycle frame and 9-bit speed.
module tb_motor_encoder_emu;

  localparam int P = 256;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       pwm = 1'b0;
  logic       in1 = 1'b0;
  logic       in2 = 1'b0;
  logic       stnby = 1'b0;
  logic       fb;
  logic       dir;
  logic       frame_tick;
  logic [8:0] speed;
  logic [8:0] duty_meas;

  int   checks = 0;
  int   fails = 0;
  int   mode = 0;
  int   pcnt = 0;
  int   toggles = 0;
  int   snap = 0;
  int   n = 0;
  logic fb_prev = 1'b0;

  int   rev_speed [17] = '{96, 72, 54, 40, 30, 22, 16, 12, 9, 6, 4, 3, 2, 1, 0, 0, 32};

  motor_encoder_emu #(
    .PWM_PERIOD (P),
    .DW         (9),
    .PHASE_MAX  (1024),
    .LAG_SHIFT  (2),
    .BRAKE_SHIFT(0)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pwm       (pwm),
    .in1       (in1),
    .in2       (in2),
    .stnby     (stnby),
    .fb        (fb),
    .dir       (dir),
    .speed     (speed),
    .duty_meas (duty_meas),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: low, 1: high, 2: 50% square of period P, 3: random
  task automatic drive_pwm();
    case (mode)
      0:       pwm = 1'b0;
      1:       pwm = 1'b1;
      2:       pwm = ((pcnt % P) < (P / 2));
      default: pwm = 1'($urandom);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pcnt++;
    if (fb !== fb_prev) toggles++;
    fb_prev = fb;
    drive_pwm();
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!frame_tick && cnt < 4 * P);
    if (!frame_tick) check("frame_tick_timeout", frame_tick, 1);
  endtask

  task automatic wait_toggle(output int cnt);
    int t0;
    t0  = toggles;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (toggles == t0 && cnt < 100);
  endtask

  // Wait for frame end, check duty, apply next-frame inputs, then check the updated speed/dir.
  task automatic update(input string tag, input int exp_duty, input int exp_speed,
                        input logic exp_dir, input int nmode, input logic ni1,
                        input logic ni2, input logic nsb, output int cnt);
    wait_tick(cnt);
    check({tag, "_duty"}, 32'(duty_meas), exp_duty);
    mode  = nmode;
    in1   = ni1;
    in2   = ni2;
    stnby = nsb;
    drive_pwm();
    tick();
    if (exp_speed >= 0) check({tag, "_speed"}, 32'(speed), exp_speed);
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
  endtask

  initial begin
    mode  = 3;
    n_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in1   = 1'($urandom);
      in2   = 1'($urandom);
      stnby = 1'($urandom);
      tick();
      check("rst_no_tick", 32'(frame_tick), 0);
    end
    check("rst_fb", 32'(fb), 0);
    check("rst_dir", 32'(dir), 1);
    check("rst_speed", 32'(speed), 0);
    check("rst_duty", 32'(duty_meas), 0);

    mode = 1; in1 = 1'b1; in2 = 1'b0; stnby = 1'b1;
    drive_pwm();
    n_rst = 1'b1;
    update("const_hi", 256, 64, 1'b1, 0, 1'b1, 1'b0, 1'b1, n);
    check("first_tick_latency", n, P);
    update("const_lo", 0, 48, 1'b1, 2, 1'b1, 1'b1, 1'b1, n);
    update("brake", 128, 0, 1'b1, 2, 1'b1, 0, 1'b1, n);
    snap = toggles;
    update("lag1", 128, 32, 1'b1, 2, 1'b1, 1'b0, 1'b1, n);
    check("brake_fb_still", toggles, snap);
    update("lag2", 128, 56, 1'b1, 2, 1'b1, 1'b0, 1'b1, n);
    update("lag3", 128, 74, 1'b1, 2, 1'b1, 1'b0, 1'b1, n);
    for (int i = 0; i < 20; i++)
      update("lag_run", 128, -1, 1'b1, 2, 1'b1, 1'b0, 1'b1, n);
    check("lag_converged", 32'(speed), 128);

    wait_toggle(n);
    wait_toggle(n);
    check("fb_period_a", n, 8);
    wait_toggle(n);
    check("fb_period_b", n, 8);

    stnby = 1'b0;
    update("coast", 128, 96, 1'b1, 2, 1'b1, 1'b0, 1'b1, n);
    for (int i = 0; i < 20; i++)
      update("refill", 128, -1, 1'b1, 2, (i != 19), (i == 19), 1'b1, n);
    check("refill_converged", 32'(speed), 128);

    for (int i = 0; i < 17; i++) begin
      update("reverse", 128, rev_speed[i], (i < 15), 2, 1'b0, 1'b1, 1'b1, n);
      if (i == 14) snap = toggles;
    end
    check("reverse_fb_still", toggles, snap);

    mode = 1;
    drive_pwm();
    for (int i = 0; i < 100; i++) tick();
    n_rst = 1'b0;
    tick();
    check("midrst_fb", 32'(fb), 0);
    check("midrst_dir", 32'(dir), 1);
    check("midrst_speed", 32'(speed), 0);
    check("midrst_duty", 32'(duty_meas), 0);
    check("midrst_tick", 32'(frame_tick), 0);
    mode = 0;
    drive_pwm();
    n_rst = 1'b1;
    wait_tick(n);
    check("midrst_latency", n, P);
    check("midrst_duty_clean", 32'(duty_meas), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
